// File: rtl/dffram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dffram_rr_arbiter
//
// Purpose:
//   Shares one single-port DFFRAM macro between two requesters
//   (port 0: CPU data path, port 1: DMA/debug). One RAM access per cycle,
//   round-robin on ties, with an optional bounded burst lock so a requester
//   can keep the RAM for up to MAX_LOCK consecutive beats.
//   The grant is combinational. Read data (old data for writes) returns to
//   the granted requester exactly one cycle after acceptance.
//
// Ports:
//   CLK, RESETn               clock (rising edge), async active-low reset
//   REQn_VALID/READY          request handshake, n = 0,1 (READY is the grant)
//   REQn_LOCK                 ask to keep the grant for the next beat
//   REQn_WE/ADDR/WDATA        byte enables (0 = read), word address, data
//   RSPn_VALID/RDATA          one-cycle response, no backpressure
//   RAM_EN0/WE0/A0/Di0        to the RAM macro
//   RAM_Do0                   from the RAM macro
// ---------------------------------------------------------------------------
module dffram_rr_arbiter #(
  parameter  int COLS     = 1,
  parameter  int MAX_LOCK = 8,
  localparam int A_WIDTH  = 7 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               REQ0_VALID,
  output logic               REQ0_READY,
  input  logic               REQ0_LOCK,
  input  logic [3:0]         REQ0_WE,
  input  logic [A_WIDTH-1:0] REQ0_ADDR,
  input  logic [31:0]        REQ0_WDATA,
  input  logic               REQ1_VALID,
  output logic               REQ1_READY,
  input  logic               REQ1_LOCK,
  input  logic [3:0]         REQ1_WE,
  input  logic [A_WIDTH-1:0] REQ1_ADDR,
  input  logic [31:0]        REQ1_WDATA,
  output logic               RSP0_VALID,
  output logic [31:0]        RSP0_RDATA,
  output logic               RSP1_VALID,
  output logic [31:0]        RSP1_RDATA,
  output logic               RAM_EN0,
  output logic [3:0]         RAM_WE0,
  output logic [A_WIDTH-1:0] RAM_A0,
  output logic [31:0]        RAM_Di0,
  input  logic [31:0]        RAM_Do0
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lockStateT;

  lockStateT  r_lockState;
  lockStateT  w_nextState;
  logic [7:0] r_lockCnt;
  logic [7:0] w_nextCnt;
  logic [7:0] w_cntInc;
  logic       r_lastGrant;
  logic       r_rspValid;
  logic       r_rspSel;
  logic       w_grant1;
  logic       w_accept;
  logic       w_winLock;
  logic       w_ownerMatch;

  // Winner selection. A lone requester always wins. On a tie the lock
  // owner wins while the lock is held; otherwise the port that did not win
  // last time. With nobody valid the mux idles on port 0 (don't care).
  always_comb begin
    w_grant1 = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      case (r_lockState)
        LOCKED0: w_grant1 = 1'b0;
        LOCKED1: w_grant1 = 1'b1;
        default: w_grant1 = ~r_lastGrant;
      endcase
    end else begin
      w_grant1 = REQ1_VALID;
    end
  end

  // A valid request is always granted, so any valid means an accept.
  assign w_accept   = REQ0_VALID | REQ1_VALID;
  assign REQ0_READY = w_accept & ~w_grant1;
  assign REQ1_READY = w_accept &  w_grant1;
  assign w_winLock  = w_grant1 ? REQ1_LOCK : REQ0_LOCK;

  // RAM pins follow the winner; the write strobe is gated so the macro
  // never sees a write while disabled.
  assign RAM_EN0 = w_accept;
  assign RAM_WE0 = w_accept ? (w_grant1 ? REQ1_WE : REQ0_WE) : 4'b0000;
  assign RAM_A0  = w_grant1 ? REQ1_ADDR  : REQ0_ADDR;
  assign RAM_Di0 = w_grant1 ? REQ1_WDATA : REQ0_WDATA;

  // Lock bookkeeping. Anything other than "winner accepted with LOCK set"
  // falls back to UNLOCKED, which covers the owner dropping VALID, the owner
  // releasing LOCK and idle cycles. A winner that is not the current owner
  // (owner went away) starts a fresh lock. Hitting MAX_LOCK still grants
  // that beat but leaves the FSM unlocked, so the next tie hands over.
  always_comb begin
    w_nextState  = UNLOCKED;
    w_nextCnt    = 8'd0;
    w_ownerMatch = ((r_lockState == LOCKED0) && !w_grant1) ||
                   ((r_lockState == LOCKED1) &&  w_grant1);
    w_cntInc     = w_ownerMatch ? (r_lockCnt + 8'd1) : 8'd1;
    if (w_accept && w_winLock && (w_cntInc < MAX_LOCK_C)) begin
      w_nextState = w_grant1 ? LOCKED1 : LOCKED0;
      w_nextCnt   = w_cntInc;
    end
  end

  // State registers. Reset drops any outstanding response and makes port 0
  // the winner of the first tie.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_lockState <= UNLOCKED;
      r_lockCnt   <= 8'd0;
      r_lastGrant <= 1'b1;
      r_rspValid  <= 1'b0;
      r_rspSel    <= 1'b0;
    end else begin
      r_lockState <= w_nextState;
      r_lockCnt   <= w_nextCnt;
      r_rspValid  <= w_accept;
      if (w_accept) begin
        r_lastGrant <= w_grant1;
        r_rspSel    <= w_grant1;
      end
    end
  end

  // Responses: RAM_Do0 belongs to whoever was accepted last cycle; the
  // other port sees zero data.
  assign RSP0_VALID = r_rspValid & ~r_rspSel;
  assign RSP1_VALID = r_rspValid &  r_rspSel;
  assign RSP0_RDATA = RSP0_VALID ? RAM_Do0 : 32'h0;
  assign RSP1_RDATA = RSP1_VALID ? RAM_Do0 : 32'h0;

endmodule

// File: tb/tb_dffram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dffram_rr_arbiter
//
// Purpose:
//   Self-checking bench for dffram_rr_arbiter. Provides a behavioural RAM
//   macro (registered read, byte writes, old data on write) and a
//   transaction-level reference model of arbitration, locking and responses.
//   Directed table vectors, hand-written lock/idle/reset sequences and a
//   randomized run are all checked against the model.
// ---------------------------------------------------------------------------
module tb_dffram_rr_arbiter;

  localparam int AW   = 7;
  localparam int MAXL = 8;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          REQ0_VALID, REQ0_READY, REQ0_LOCK;
  logic [3:0]    REQ0_WE;
  logic [AW-1:0] REQ0_ADDR;
  logic [31:0]   REQ0_WDATA;
  logic          REQ1_VALID, REQ1_READY, REQ1_LOCK;
  logic [3:0]    REQ1_WE;
  logic [AW-1:0] REQ1_ADDR;
  logic [31:0]   REQ1_WDATA;
  logic          RSP0_VALID, RSP1_VALID;
  logic [31:0]   RSP0_RDATA, RSP1_RDATA;
  logic          RAM_EN0;
  logic [3:0]    RAM_WE0;
  logic [AW-1:0] RAM_A0;
  logic [31:0]   RAM_Di0;
  logic [31:0]   RAM_Do0;

  dffram_rr_arbiter #(.COLS(1), .MAX_LOCK(MAXL)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_LOCK(REQ0_LOCK),
    .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_LOCK(REQ1_LOCK),
    .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
    .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA),
    .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA),
    .RAM_EN0(RAM_EN0), .RAM_WE0(RAM_WE0), .RAM_A0(RAM_A0),
    .RAM_Di0(RAM_Di0), .RAM_Do0(RAM_Do0)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM macro: registered read of the old word, byte writes.
  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] ramDo = 32'h0;
  assign RAM_Do0 = ramDo;

  always @(posedge CLK) begin
    if (RAM_EN0) begin
      ramDo <= ram[RAM_A0];
      for (int b = 0; b < 4; b++)
        if (RAM_WE0[b]) ram[RAM_A0][8*b +: 8] <= RAM_Di0[8*b +: 8];
    end
  end

  typedef struct {
    logic          v0, l0;
    logic [3:0]    we0;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic          v1, l1;
    logic [3:0]    we1;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
  } reqT;

  typedef struct {
    reqT         req;
    logic [1:0]  expReady;
    logic [1:0]  expRspValid;
    logic [31:0] expRdata;
  } vecT;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, kept as plain integers and an array.
  logic [31:0] shadow [0:(1<<AW)-1];
  int          mLastGrant, mLockOwner, mLockCnt, mRspPort, mWinner;
  logic [31:0] mRspData;
  reqT         cur;

  function automatic reqT mkReq(input logic v0, input logic l0, input logic [3:0] we0,
                                input logic [AW-1:0] a0, input logic [31:0] d0,
                                input logic v1, input logic l1, input logic [3:0] we1,
                                input logic [AW-1:0] a1, input logic [31:0] d1);
    reqT r;
    r.v0 = v0; r.l0 = l0; r.we0 = we0; r.a0 = a0; r.d0 = d0;
    r.v1 = v1; r.l1 = l1; r.we1 = we1; r.a1 = a1; r.d1 = d1;
    return r;
  endfunction

  function automatic reqT idleReq();
    return mkReq(0, 0, 4'h0, '0, 32'h0, 0, 0, 4'h0, '0, 32'h0);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mLastGrant = 1;
    mLockOwner = -1;
    mLockCnt   = 0;
    mRspPort   = -1;
    mRspData   = 32'h0;
  endtask

  // Drive one cycle of requests just after the falling edge and predict the
  // winner from the rules: lone requester wins, tie goes to the lock owner or
  // else to the port that did not win last.
  task automatic applyStimulus(input reqT r);
    @(negedge CLK);
    cur = r;
    REQ0_VALID = r.v0; REQ0_LOCK = r.l0; REQ0_WE = r.we0; REQ0_ADDR = r.a0; REQ0_WDATA = r.d0;
    REQ1_VALID = r.v1; REQ1_LOCK = r.l1; REQ1_WE = r.we1; REQ1_ADDR = r.a1; REQ1_WDATA = r.d1;
    #1;
    if (r.v0 && r.v1) mWinner = (mLockOwner >= 0) ? mLockOwner : 1 - mLastGrant;
    else if (r.v0)    mWinner = 0;
    else if (r.v1)    mWinner = 1;
    else              mWinner = -1;
  endtask

  task automatic checkOutput();
    checkVal("ready0", REQ0_READY, mWinner == 0);
    checkVal("ready1", REQ1_READY, mWinner == 1);
    checkVal("ramEn",  RAM_EN0,    mWinner >= 0);
    if (mWinner == 0) begin
      checkVal("ramWe", RAM_WE0, cur.we0);
      checkVal("ramA",  RAM_A0,  cur.a0);
      checkVal("ramDi", RAM_Di0, cur.d0);
    end else if (mWinner == 1) begin
      checkVal("ramWe", RAM_WE0, cur.we1);
      checkVal("ramA",  RAM_A0,  cur.a1);
      checkVal("ramDi", RAM_Di0, cur.d1);
    end else begin
      checkVal("ramWeIdle", RAM_WE0, 4'h0);
    end
    checkVal("rspValid0", RSP0_VALID, mRspPort == 0);
    checkVal("rspValid1", RSP1_VALID, mRspPort == 1);
    checkVal("rspData0",  RSP0_RDATA, (mRspPort == 0) ? mRspData : 32'h0);
    checkVal("rspData1",  RSP1_RDATA, (mRspPort == 1) ? mRspData : 32'h0);
  endtask

  // Commit the predicted transaction at the rising edge.
  task automatic advanceCycle();
    logic [AW-1:0] a;
    logic [3:0]    we;
    logic [31:0]   d;
    logic          lk;
    @(posedge CLK);
    if (mWinner >= 0) begin
      a  = (mWinner == 0) ? cur.a0  : cur.a1;
      we = (mWinner == 0) ? cur.we0 : cur.we1;
      d  = (mWinner == 0) ? cur.d0  : cur.d1;
      lk = (mWinner == 0) ? cur.l0  : cur.l1;
      mRspData = shadow[a];
      for (int b = 0; b < 4; b++)
        if (we[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
      mRspPort   = mWinner;
      mLastGrant = mWinner;
      if (!lk) begin
        mLockOwner = -1;
        mLockCnt   = 0;
      end else begin
        if (mLockOwner == mWinner) mLockCnt++;
        else begin
          mLockOwner = mWinner;
          mLockCnt   = 1;
        end
        if (mLockCnt >= MAXL) begin
          mLockOwner = -1;
          mLockCnt   = 0;
        end
      end
    end else begin
      mRspPort   = -1;
      mLockOwner = -1;
      mLockCnt   = 0;
    end
  endtask

  task automatic runCycle(input reqT r);
    applyStimulus(r);
    checkOutput();
    advanceCycle();
  endtask

  vecT vecs [12];
  int  lockPat [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    reqT r, pend0, pend1;
    logic hold0, hold1;

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 32'h0;
      shadow[i] = 32'h0;
    end

    // Reset state.
    RESETn = 1'b0;
    r = idleReq();
    REQ0_VALID = 0; REQ0_LOCK = 0; REQ0_WE = 0; REQ0_ADDR = 0; REQ0_WDATA = 0;
    REQ1_VALID = 0; REQ1_LOCK = 0; REQ1_WE = 0; REQ1_ADDR = 0; REQ1_WDATA = 0;
    modelReset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkVal("rstRsp0", RSP0_VALID, 1'b0);
    checkVal("rstRsp1", RSP1_VALID, 1'b0);
    checkVal("rstEn",   RAM_EN0,    1'b0);
    RESETn = 1'b1;

    // Directed table: full write/readback, byte write, alternating reads.
    vecs[0]  = '{mkReq(1,0,4'hF,7'd5,32'hDEADBEEF, 0,0,4'h0,7'd0,32'h0), 2'b01, 2'b00, 32'h0};
    vecs[1]  = '{mkReq(1,0,4'h0,7'd5,32'h0,        0,0,4'h0,7'd0,32'h0), 2'b01, 2'b01, 32'h0};
    vecs[2]  = '{idleReq(),                                                2'b00, 2'b01, 32'hDEADBEEF};
    vecs[3]  = '{mkReq(1,0,4'hF,7'd9,32'h11223344, 0,0,4'h0,7'd0,32'h0), 2'b01, 2'b00, 32'h0};
    vecs[4]  = '{mkReq(1,0,4'h2,7'd9,32'h0000AB00, 0,0,4'h0,7'd0,32'h0), 2'b01, 2'b01, 32'h0};
    vecs[5]  = '{mkReq(1,0,4'h0,7'd9,32'h0,        0,0,4'h0,7'd0,32'h0), 2'b01, 2'b01, 32'h11223344};
    vecs[6]  = '{idleReq(),                                                2'b00, 2'b01, 32'h1122AB44};
    vecs[7]  = '{mkReq(1,0,4'h0,7'd5,32'h0,        1,0,4'h0,7'd9,32'h0), 2'b10, 2'b00, 32'h0};
    vecs[8]  = '{mkReq(1,0,4'h0,7'd5,32'h0,        1,0,4'h0,7'd9,32'h0), 2'b01, 2'b10, 32'h1122AB44};
    vecs[9]  = '{mkReq(1,0,4'h0,7'd5,32'h0,        1,0,4'h0,7'd9,32'h0), 2'b10, 2'b01, 32'hDEADBEEF};
    vecs[10] = '{mkReq(1,0,4'h0,7'd5,32'h0,        1,0,4'h0,7'd9,32'h0), 2'b01, 2'b10, 32'h1122AB44};
    vecs[11] = '{idleReq(),                                                2'b00, 2'b01, 32'hDEADBEEF};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].req);
      checkOutput();
      checkVal($sformatf("tbl%0d_ready", i),    {REQ1_READY, REQ0_READY}, vecs[i].expReady);
      checkVal($sformatf("tbl%0d_rspValid", i), {RSP1_VALID, RSP0_VALID}, vecs[i].expRspValid);
      checkVal($sformatf("tbl%0d_rdata", i),    RSP0_RDATA | RSP1_RDATA,  vecs[i].expRdata);
      advanceCycle();
    end

    // Burst lock: port 1 alone first so the first tie belongs to port 0,
    // then port 0 locks against a waiting port 1 for 12 beats.
    runCycle(mkReq(0,0,4'h0,7'd5,32'h0, 1,0,4'h0,7'd9,32'h0));
    for (int i = 0; i < 12; i++) begin
      applyStimulus(mkReq(1,1,4'h0,7'd5,32'h0, 1,0,4'h0,7'd9,32'h0));
      checkOutput();
      checkVal($sformatf("lock%0d_grant1", i), REQ1_READY, lockPat[i] == 1);
      advanceCycle();
    end
    runCycle(mkReq(0,0,4'h0,7'd5,32'h0, 1,0,4'h0,7'd9,32'h0));
    runCycle(idleReq());

    // Idle stretch: RAM disabled, no write strobe, no responses.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(idleReq());
      checkOutput();
      checkVal($sformatf("idle%0d_en", i),  RAM_EN0, 1'b0);
      checkVal($sformatf("idle%0d_we", i),  RAM_WE0, 4'h0);
      checkVal($sformatf("idle%0d_rsp", i), {RSP1_VALID, RSP0_VALID}, 2'b00);
    end

    // Reset one cycle after an accept: the response is dropped and the
    // first tie afterwards goes to port 0 again.
    runCycle(mkReq(1,0,4'h0,7'd5,32'h0, 0,0,4'h0,7'd0,32'h0));
    #1 RESETn = 1'b0;
    modelReset();
    applyStimulus(idleReq());
    checkOutput();
    checkVal("rstMid_rsp", {RSP1_VALID, RSP0_VALID}, 2'b00);
    advanceCycle();
    #2 RESETn = 1'b1;
    applyStimulus(idleReq());
    checkOutput();
    checkVal("rstAfter_rsp", {RSP1_VALID, RSP0_VALID}, 2'b00);
    advanceCycle();
    applyStimulus(mkReq(1,0,4'h0,7'd5,32'h0, 1,0,4'h0,7'd9,32'h0));
    checkOutput();
    checkVal("rstTie_port0", REQ0_READY, 1'b1);
    advanceCycle();
    runCycle(mkReq(0,0,4'h0,7'd5,32'h0, 1,0,4'h0,7'd9,32'h0));
    runCycle(idleReq());

    // Randomized traffic; a requester that was not granted keeps its request.
    hold0 = 1'b0;
    hold1 = 1'b0;
    pend0 = idleReq();
    pend1 = idleReq();
    for (int n = 0; n < 400; n++) begin
      r = idleReq();
      if (hold0) begin
        r.v0 = pend0.v0; r.l0 = pend0.l0; r.we0 = pend0.we0; r.a0 = pend0.a0; r.d0 = pend0.d0;
      end else begin
        r.v0  = ($urandom_range(0, 2) != 0);
        r.l0  = ($urandom_range(0, 3) != 0);
        r.we0 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        r.a0  = AW'($urandom_range(0, 15));
        r.d0  = $urandom;
      end
      if (hold1) begin
        r.v1 = pend1.v1; r.l1 = pend1.l1; r.we1 = pend1.we1; r.a1 = pend1.a1; r.d1 = pend1.d1;
      end else begin
        r.v1  = ($urandom_range(0, 2) != 0);
        r.l1  = ($urandom_range(0, 3) != 0);
        r.we1 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        r.a1  = AW'($urandom_range(0, 15));
        r.d1  = $urandom;
      end
      applyStimulus(r);
      checkOutput();
      hold0 = r.v0 && (mWinner != 0);
      hold1 = r.v1 && (mWinner != 1);
      pend0 = r;
      pend1 = r;
      advanceCycle();
    end
    runCycle(idleReq());
    runCycle(idleReq());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
